// File: rtl/mem_interface.sv
// Processor-to-memory handshake bridge: latches one access, issues it to memory, returns read data.
// Latency: stall covers the detect cycle plus every REQ cycle (min 2 cycles); rdata/rvalid appear in DONE.
// Backpressure: stall holds the processor until mem_ack or timeout; a timeout parks the block in ERR until reset.
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   MemRead, MemWrite     access strobes (both high = write); addr, wdata = access operands
//   rdata, rvalid         registered read data and its one-cycle update pulse
//   stall, err            processor hold request, sticky timeout flag
//   mem_req, mem_we,      memory request and its latched type/address/write data,
//   mem_addr, mem_wdata   driven only while mem_req is high (zero otherwise)
//   mem_rdata, mem_ack    memory read data and completion, looked at only during a request
module mem_interface #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              stall,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  // Counter only has to reach TIMEOUT-1; keep at least one bit for TIMEOUT=1.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  wait_cnt;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              strobe;

  assign strobe = MemRead | MemWrite;

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    mem_req   = 1'b0;
    rvalid    = 1'b0;
    err       = 1'b0;
    case (state)
      IDLE: begin
        // Stall goes high in the detect cycle so the processor freezes immediately.
        if (strobe) begin
          stall     = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        stall   = 1'b1;
        mem_req = 1'b1;
        // Ack wins over a timeout landing in the same cycle.
        if (mem_ack) begin
          state_nxt = DONE;
        end else if (wait_cnt == CNT_MAX) begin
          state_nxt = ERR;
        end
      end
      DONE: begin
        // Strobes are still up here (processor advances at the end of DONE),
        // so they are deliberately not examined.
        rvalid    = ~we_q;
        state_nxt = IDLE;
      end
      ERR: begin
        err   = 1'b1;
        stall = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Memory-side fields are gated so they read zero whenever no request is open.
  assign mem_we    = mem_req & we_q;
  assign mem_addr  = mem_req ? addr_q  : '0;
  assign mem_wdata = mem_req ? wdata_q : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (strobe) begin
            we_q     <= MemWrite;
            addr_q   <= addr;
            wdata_q  <= wdata;
            wait_cnt <= '0;
          end
        end
        REQ: begin
          if (mem_ack) begin
            wait_cnt <= '0;
            if (!we_q) begin
              rdata <= mem_rdata;
            end
          end else if (wait_cnt != CNT_MAX) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_interface.sv
module tb_mem_interface;

  localparam int DW = 8;
  localparam int AW = 8;
  localparam int TO = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          MemRead = 1'b0;
  logic          MemWrite = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic [DW-1:0] rdata;
  logic          rvalid;
  logic          stall;
  logic          err;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ack = 1'b0;

  mem_interface #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .addr(addr), .wdata(wdata), .rdata(rdata), .rvalid(rvalid), .stall(stall),
    .err(err), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model state: what each request must look like, what each read returns,
  // and the value rdata must hold between reads.
  logic [16:0]   exp_req[$];
  logic [DW-1:0] exp_rd[$];
  logic [DW-1:0] model_rdata = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expected request on each rising mem_req and one read value per rvalid.
  logic        prev_req = 1'b0;
  logic [16:0] cur_req = '0;
  always @(negedge clock) begin
    if (reset) begin
      prev_req = 1'b0;
    end else begin
      if (mem_req) begin
        if (!prev_req) begin
          checks++;
          if (exp_req.size() == 0) begin
            errors++;
            cur_req = {mem_we, mem_addr, mem_wdata};
            $display("FAIL unexpected_req actual=%h expected=none", cur_req);
          end else begin
            cur_req = exp_req.pop_front();
            checks--;
            chk("req_fields", 32'({mem_we, mem_addr, mem_wdata}), 32'(cur_req));
          end
        end else begin
          chk("req_stable", 32'({mem_we, mem_addr, mem_wdata}), 32'(cur_req));
        end
      end
      if (rvalid) begin
        if (exp_rd.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rvalid actual=%h expected=no_pulse", rdata);
        end else begin
          chk("rdata", 32'(rdata), 32'(exp_rd.pop_front()));
        end
      end
      prev_req = mem_req;
    end
  end

  task automatic do_reset();
    reset    = 1'b1;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    mem_ack  = 1'b0;
    @(posedge clock); #1;
    @(negedge clock);
    chk("reset_outputs",
        32'({stall, rvalid, err, mem_req, mem_we, mem_addr, mem_wdata, rdata}), 32'(0));
    @(posedge clock); #1;
    reset = 1'b0;
    model_rdata = '0;
  endtask

  // One complete processor access. Entered just after a rising edge with the DUT idle;
  // returns just after the edge that ends DONE. dly = REQ cycles before the ack cycle.
  task automatic access(input logic rd, input logic wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, input int dly, input logic [DW-1:0] mrd,
                        input logic hold);
    int nstall = 0;
    exp_req.push_back({wr, a, wd});
    if (!wr) exp_rd.push_back(mrd);
    MemRead  = rd;
    MemWrite = wr;
    addr     = a;
    wdata    = wd;
    mem_ack  = 1'($urandom_range(1));
    mem_rdata = 8'($urandom_range(255));
    @(negedge clock);
    if (stall) nstall++;
    for (int k = 0; k <= dly; k++) begin
      @(posedge clock); #1;
      mem_ack   = (k == dly);
      mem_rdata = (k == dly) ? mrd : 8'($urandom_range(255));
      @(negedge clock);
      if (stall) nstall++;
    end
    @(posedge clock); #1;
    mem_ack   = 1'($urandom_range(1));
    mem_rdata = 8'($urandom_range(255));
    if (!hold) begin
      MemRead  = 1'b0;
      MemWrite = 1'b0;
    end
    @(negedge clock);
    if (stall) nstall++;
    chk("stall_cycles", 32'(nstall), 32'(dly + 2));
    @(posedge clock); #1;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    mem_ack  = 1'b0;
    if (!wr) model_rdata = mrd;
  endtask

  // Idle cycle with stray acks: nothing may move and rdata must hold its last read value.
  task automatic idle_cycle();
    mem_ack   = 1'($urandom_range(1));
    mem_rdata = 8'($urandom_range(255));
    @(negedge clock);
    chk("idle_hold", 32'({stall, mem_req, err, rdata}), 32'({3'b000, model_rdata}));
    @(posedge clock); #1;
    mem_ack = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int nreq;
    logic seen_err;

    do_reset();
    // Read right after reset, ack in the third REQ cycle.
    access(1'b1, 1'b0, 8'h3A, 8'h00, 2, 8'h5C, 1'b0);
    idle_cycle();
    // Write acked in the first REQ cycle; rdata must keep 0x5C.
    access(1'b0, 1'b1, 8'h10, 8'hA5, 0, 8'hEE, 1'b0);
    idle_cycle();
    // Both strobes act as a write.
    access(1'b1, 1'b1, 8'h42, 8'h77, 1, 8'h99, 1'b0);
    idle_cycle();
    // Strobe held through DONE, then a fresh read straight away.
    access(1'b1, 1'b0, 8'h21, 8'h00, 1, 8'h13, 1'b1);
    access(1'b1, 1'b0, 8'h84, 8'h00, 0, 8'hC4, 1'b0);
    idle_cycle();
    // Held strobe, then idle: a duplicate request would show as an unexpected one.
    access(1'b1, 1'b0, 8'h55, 8'h00, 0, 8'h3C, 1'b1);
    idle_cycle();
    idle_cycle();
    // Ack lands in the cycle the timeout would fire.
    access(1'b1, 1'b0, 8'h66, 8'h00, TO - 1, 8'hB7, 1'b0);
    idle_cycle();

    // Reset in the second REQ cycle.
    MemRead = 1'b1;
    addr    = 8'h9A;
    wdata   = 8'h00;
    exp_req.push_back({1'b0, 8'h9A, 8'h00});
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset   = 1'b0;
    MemRead = 1'b0;
    model_rdata = '0;
    @(negedge clock);
    chk("after_mid_reset", 32'({mem_req, stall, rdata}), 32'(0));
    @(posedge clock); #1;
    access(1'b1, 1'b0, 8'h9A, 8'h00, 1, 8'h4D, 1'b0);
    idle_cycle();

    // Randomized traffic against the model.
    for (int n = 0; n < 60; n++) begin
      logic rd, wr;
      int   op;
      op = int'($urandom_range(2));
      rd = (op != 1);
      wr = (op != 0);
      access(rd, wr, 8'($urandom_range(255)), 8'($urandom_range(255)),
             int'($urandom_range(TO - 1)), 8'($urandom_range(255)),
             1'($urandom_range(1)));
      if ($urandom_range(1) == 1) idle_cycle();
      else if ($urandom_range(3) == 0) begin
        idle_cycle();
        idle_cycle();
      end
    end
    idle_cycle();

    // Timeout: no ack ever; mem_req must be up exactly TO cycles before ERR.
    MemRead = 1'b1;
    addr    = 8'hE1;
    wdata   = 8'h00;
    exp_req.push_back({1'b0, 8'hE1, 8'h00});
    nreq = 0;
    seen_err = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (mem_req) nreq++;
      if (err) begin
        seen_err = 1'b1;
        break;
      end
      @(posedge clock); #1;
    end
    chk("timeout_req_cycles", 32'(nreq), 32'(TO));
    chk("timeout_err_seen", 32'(seen_err), 32'(1));
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      mem_ack   = 1'b1;
      mem_rdata = 8'($urandom_range(255));
      @(negedge clock);
      chk("err_sticky", 32'({err, stall, mem_req, rvalid, rdata}), 32'({4'b1100, model_rdata}));
    end
    @(posedge clock); #1;
    do_reset();
    access(1'b1, 1'b0, 8'h07, 8'h00, 0, 8'h81, 1'b0);
    idle_cycle();

    chk("queues_drained", 32'(exp_req.size() + exp_rd.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_interface.md
MEM_INTERFACE -- requirements
Module: mem_interface

Interface
REQ-001 Parameter DATA_W, default 8, data width in bits.
REQ-002 Parameter ADDR_W, default 8, address width in bits.
REQ-003 Parameter TIMEOUT, default 15, maximum wait cycles for mem_ack before error; legal range 1..255.
REQ-004 clock  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 MemRead  input  1  read strobe from processor control FSM.
REQ-007 MemWrite  input  1  write strobe from processor control FSM.
REQ-008 addr  input  ADDR_W  access address from processor datapath.
REQ-009 wdata  input  DATA_W  store data from processor datapath.
REQ-010 rdata  output  DATA_W  registered read data, held until the next completed read.
REQ-011 rvalid  output  1  one-cycle pulse when rdata is updated by a completed read.
REQ-012 stall  output  1  processor must hold its state and strobes while high.
REQ-013 err  output  1  sticky timeout flag.
REQ-014 mem_req  output  1  request to external memory.
REQ-015 mem_we  output  1  1 = write, 0 = read; valid while mem_req is high.
REQ-016 mem_addr  output  ADDR_W  latched address; valid while mem_req is high.
REQ-017 mem_wdata  output  DATA_W  latched write data; valid while mem_req is high.
REQ-018 mem_rdata  input  DATA_W  read data from memory; sampled in the cycle mem_ack is high.
REQ-019 mem_ack  input  1  memory completion; ignored unless mem_req is high.

Function
REQ-020 The block SHALL implement the states IDLE, REQ, DONE and ERR.
REQ-021 IDLE: when MemRead or MemWrite is high, the block SHALL latch addr, wdata and the access type, assert stall combinationally in the same cycle, and go to REQ.
REQ-022 MemRead and MemWrite both high in IDLE SHALL be treated as a write.
REQ-023 IDLE with no strobe: stall=0, mem_req=0, no state change.
REQ-024 REQ: mem_req=1, stall=1, and mem_we/mem_addr/mem_wdata SHALL be driven from the latched values, stable for the whole request.
REQ-025 REQ with mem_ack=1: for a read, rdata SHALL load mem_rdata at that edge; next state DONE; wait counter cleared.
REQ-026 REQ with mem_ack=0: the wait counter SHALL increment; when the counter equals TIMEOUT-1 and ack is still low, next state ERR.
REQ-027 mem_ack arriving in the same cycle the timeout would fire SHALL take priority (completion, not error).
REQ-028 Request latency: at least 1 REQ cycle; ack in the first REQ cycle gives total stall of 2 cycles (IDLE detect + REQ).
REQ-029 DONE: stall=0 and mem_req=0; rvalid=1 only if the completed access was a read; unconditional return to IDLE.
REQ-030 Strobes present in DONE SHALL be ignored (the processor FSM advances at the end of DONE).
REQ-031 ERR: err=1, stall=1, mem_req=0; the block SHALL remain in ERR until reset.
REQ-032 rdata SHALL NOT change on writes, timeouts, or idle cycles.
REQ-033 mem_ack high outside REQ SHALL have no effect.
REQ-034 The wait counter SHALL be wide enough to hold TIMEOUT-1 without wrap and SHALL be cleared on every entry to REQ.

Reset
REQ-035 reset high at a clock edge SHALL force state IDLE, counter 0, rdata 0, latched address/data/type 0, in any state including REQ and ERR.
REQ-036 During and immediately after reset: stall=0, rvalid=0, err=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-037 A strobe in the first cycle after reset deasserts SHALL be accepted normally.

Verification
REQ-038 Read: MemRead=1, addr=0x3A; mem_ack=1 with mem_rdata=0x5C in the 3rd REQ cycle -> mem_addr=0x3A, mem_we=0 for 3 cycles, stall high 4 cycles, rdata=0x5C, rvalid pulse 1 cycle in DONE.
REQ-039 Write: MemWrite=1, addr=0x10, wdata=0xA5, ack in the 1st REQ cycle -> mem_we=1, mem_wdata=0xA5, stall 2 cycles, rvalid stays 0, rdata unchanged.
REQ-040 Timeout: TIMEOUT=4, MemRead=1, no ack -> mem_req high exactly 4 cycles, then err=1, stall=1, mem_req=0 held until reset; ack at cycle 4 instead -> normal completion, err=0.
REQ-041 Both strobes high with wdata=0x77 -> mem_we=1, mem_wdata=0x77, no read data capture.
REQ-042 Reset asserted in the 2nd REQ cycle -> next cycle mem_req=0, stall=0, rdata=0x00; a following read completes normally.
REQ-043 Back-to-back: read completes, strobe held through DONE, new read strobe in the following IDLE -> exactly one access per strobe episode, no duplicate request from DONE.
